alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Parametrised successor to the single-shot ALU enable controller.
- Turns execute-button presses into one-cycle register-enable pulses for N operand registers and the result register Y.
- LOAD presses fill operand registers in round-robin order through an internal pointer.
- Other opcodes are latched and held for a fixed ALU latency, then Y is written. Busy/done status is reported.
- Sits between the board input synchroniser and the ALU datapath registers.

Parameters:
- OP_W, 4, opcode width.
- NUM_OPERANDS, 2, number of operand registers (2..8). Pointer width PTR_W = clog2(NUM_OPERANDS), minimum 1.
- ALU_LATENCY, 1, cycles from op_select update to the enable_Y pulse (1..15).
- LOAD_OP, all-ones of OP_W, opcode that loads the next operand register.
- CLR_OP, 0, opcode that resets the operand pointer; no ALU operation is issued.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_execute  input  1  execute button, already synchronised to clk, level
- operation  input  OP_W  opcode, sampled on the accepted edge
- load_en  output  NUM_OPERANDS  one-hot operand register enable, one-cycle pulse
- enable_Y  output  1  result register enable, one-cycle pulse
- op_select  output  OP_W  opcode driven to the ALU, held until the next accepted op
- operand_ptr  output  PTR_W  index of the next operand register to be loaded
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse coincident with enable_Y

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clk is the clock. All outputs are registered.
- Reset values:
  - load_en = 0, enable_Y = 0, op_select = 0, operand_ptr = 0, busy = 0, done = 0.
  - State = IDLE, latency counter = 0.
  - Button history register btn_q = 1, so a button held through reset release does not fire.
- Edge detect: press = btn_execute & ~btn_q, evaluated every cycle; btn_q <= btn_execute each cycle. One press produces exactly one action.
- States: IDLE, WAIT, WRITE.
- IDLE, press with operation == LOAD_OP:
  - load_en[operand_ptr] = 1 for exactly the next cycle.
  - operand_ptr increments, wrapping from NUM_OPERANDS-1 to 0.
  - State stays IDLE; busy stays 0.
- IDLE, press with operation == CLR_OP:
  - operand_ptr <= 0. No enables; state stays IDLE.
- IDLE, press with any other opcode:
  - op_select <= operation, busy <= 1, counter <= ALU_LATENCY-1, go to WAIT.
  - If edge is sampled at cycle t, op_select is valid from t+1.
- WAIT:
  - Counter decrements each cycle.
  - At 0, go to WRITE and assert enable_Y and done for the next cycle.
  - enable_Y is high exactly in cycle t+1+ALU_LATENCY.
- WRITE:
  - One cycle with enable_Y = done = busy = 1.
  - Next cycle: busy = 0, state IDLE.
- Presses while busy (WAIT or WRITE) are dropped, not queued. The edge is still consumed: btn_q updates, and a button held past busy does not fire.
- Pulse exclusivity: load_en and enable_Y are never high in the same cycle. At most one load_en bit is high at any time.
- op_select holds its last value after WRITE and across LOAD/CLR presses.
- Reset mid-operation (any state): immediately returns all outputs and state to reset values. A pending enable_Y is cancelled.
- Opcode collision: if LOAD_OP == CLR_OP, LOAD takes priority.

Test Plan:
- Reset release with btn_execute held at 1, then released and pressed again -> no action on release; exactly one action on the second press.
- NUM_OPERANDS=3: four LOAD_OP presses -> load_en = 001, 010, 100, 001, each one cycle wide; operand_ptr goes 1, 2, 0, 1.
- ALU_LATENCY=3: press with operation=4'h2 at cycle t -> op_select=2 from t+1; busy high t+1..t+4; enable_Y and done high only at t+4.
- During WAIT, a second press with operation=4'h5 -> ignored; op_select stays 2; exactly one enable_Y pulse.
- Two LOAD presses, then CLR_OP press, then LOAD press -> operand_ptr = 0 after CLR; load_en = 01 on the final press.
- Assert reset in the WAIT cycle preceding WRITE -> enable_Y never pulses; all outputs 0; operand_ptr 0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Turns execute-button presses into one-cycle register-enable pulses for
//   the ALU datapath. LOAD presses strobe the operand registers in round-robin
//   order. CLR presses rewind the operand pointer. Any other opcode is latched
//   onto op_select and held for ALU_LATENCY cycles, after which the result
//   register Y is strobed.
//
// Ports
//   clk, reset    clock and asynchronous active-high reset
//   btn_execute   synchronised execute button (level)
//   operation     opcode, sampled on the edge that accepts a press
//   load_en       one-hot operand register enable, one-cycle pulse
//   enable_Y      result register enable, one-cycle pulse
//   op_select     opcode driven to the ALU, held until the next accepted op
//   operand_ptr   index of the next operand register to be loaded
//   busy          operation in flight (WAIT or WRITE)
//   done          one-cycle pulse coincident with enable_Y
//   dbg_state     current FSM state (0 IDLE, 1 WAIT, 2 WRITE)
//
// Handshake: there is no valid/ready pair. btn_execute acts as a valid that
// is accepted only on its rising edge while IDLE. Edges seen while busy are
// dropped, not queued.
module alu_op_sequencer #(
    parameter int              OP_W         = 4,
    parameter int              NUM_OPERANDS = 2,
    parameter int              ALU_LATENCY  = 1,
    parameter logic [OP_W-1:0] LOAD_OP      = '1,
    parameter logic [OP_W-1:0] CLR_OP       = '0,
    localparam int             PTR_W        = (NUM_OPERANDS > 2) ? $clog2(NUM_OPERANDS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_execute,
    input  logic [OP_W-1:0]         operation,
    output logic [NUM_OPERANDS-1:0] load_en,
    output logic                    enable_Y,
    output logic [OP_W-1:0]         op_select,
    output logic [PTR_W-1:0]        operand_ptr,
    output logic                    busy,
    output logic                    done,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t                  state, state_d;
    logic [3:0]              cnt, cnt_d;
    logic                    btn_q;
    logic                    press;
    logic                    is_load, is_clr;
    logic [NUM_OPERANDS-1:0] load_en_d;
    logic [OP_W-1:0]         op_select_d;
    logic [PTR_W-1:0]        ptr_d;

    assign press   = btn_execute & ~btn_q;
    // LOAD is tested first so it wins if both opcodes share a value.
    assign is_load = (operation == LOAD_OP);
    assign is_clr  = !is_load && (operation == CLR_OP);

    assign dbg_state = state;

    // State and output registers. btn_q resets high so a button held
    // through reset release is not seen as a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_q       <= 1'b1;
            load_en     <= '0;
            enable_Y    <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            op_select   <= '0;
            operand_ptr <= '0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            btn_q       <= btn_execute;
            load_en     <= load_en_d;
            enable_Y    <= (state_d == WRITE);
            done        <= (state_d == WRITE);
            busy        <= (state_d != IDLE);
            op_select   <= op_select_d;
            operand_ptr <= ptr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (press && !is_load && !is_clr) state_d = WAIT;
            WAIT:    if (cnt == 4'd0) state_d = WRITE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and the latency counter.
    always_comb begin
        cnt_d       = cnt;
        load_en_d   = '0;
        op_select_d = op_select;
        ptr_d       = operand_ptr;
        case (state)
            IDLE: begin
                if (press) begin
                    if (is_load) begin
                        load_en_d = NUM_OPERANDS'(1) << operand_ptr;
                        if (operand_ptr == PTR_W'(NUM_OPERANDS - 1))
                            ptr_d = '0;
                        else
                            ptr_d = operand_ptr + 1'b1;
                    end else if (is_clr) begin
                        ptr_d = '0;
                    end else begin
                        op_select_d = operation;
                        cnt_d       = 4'(ALU_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt != 4'd0) cnt_d = cnt - 4'd1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    localparam int OP_W = 4;
    localparam int N    = 3;
    localparam int LAT  = 3;

    logic            clk = 1'b0;
    logic            reset;
    logic            btn_execute;
    logic [OP_W-1:0] operation;
    logic [N-1:0]    load_en;
    logic            enable_Y;
    logic [OP_W-1:0] op_select;
    logic [1:0]      operand_ptr;
    logic            busy;
    logic            done;
    logic [1:0]      dbg_state;

    int checks = 0;
    int errors = 0;
    int ey_pulses = 0;
    int ey_base;

    alu_op_sequencer #(
        .OP_W(OP_W), .NUM_OPERANDS(N), .ALU_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .btn_execute(btn_execute),
        .operation(operation), .load_en(load_en), .enable_Y(enable_Y),
        .op_select(op_select), .operand_ptr(operand_ptr), .busy(busy),
        .done(done), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [31:0] exp_ptr, input logic [31:0] exp_op);
        chk({tag, " load_en"}, 32'(load_en), 0);
        chk({tag, " enable_Y"}, 32'(enable_Y), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " ptr"}, 32'(operand_ptr), exp_ptr);
        chk({tag, " op_select"}, 32'(op_select), exp_op);
        chk({tag, " state"}, 32'(dbg_state), 0);
    endtask

    task automatic press_load(input string tag, input logic [31:0] exp_en, input logic [31:0] exp_ptr);
        operation   = 4'hF;
        btn_execute = 1'b1;
        tick();
        chk({tag, " load_en"}, 32'(load_en), exp_en);
        chk({tag, " ptr"}, 32'(operand_ptr), exp_ptr);
        chk({tag, " busy"}, 32'(busy), 0);
        btn_execute = 1'b0;
        tick();
        chk({tag, " load_en width"}, 32'(load_en), 0);
    endtask

    // pulse monitor: counts enable_Y pulses and checks pulse exclusivity
    always @(negedge clk) begin
        if (enable_Y) ey_pulses++;
        if (!reset) begin
            checks++;
            assert (!(enable_Y && (load_en != 0)) && ((load_en & (load_en - 1'b1)) == 0)) else begin
                errors++;
                $error("FAIL exclusivity: load_en %b enable_Y %b expected onehot0 and not both", load_en, enable_Y);
            end
        end
    end

    initial begin
        // reset with button held high and LOAD selected
        reset       = 1'b1;
        btn_execute = 1'b1;
        operation   = 4'hF;
        tick();
        tick();
        chk_idle("reset", 0, 0);
        reset = 1'b0;
        tick();
        tick();
        chk_idle("held after reset", 0, 0);
        btn_execute = 1'b0;
        tick();
        chk_idle("release", 0, 0);

        // four LOAD presses wrap the pointer
        press_load("load1", 32'b001, 1);
        press_load("load2", 32'b010, 2);
        press_load("load3", 32'b100, 0);
        press_load("load4", 32'b001, 1);

        // CLR rewinds the pointer, next LOAD hits register 0
        operation   = 4'h0;
        btn_execute = 1'b1;
        tick();
        chk_idle("clr", 0, 0);
        btn_execute = 1'b0;
        tick();
        press_load("load after clr", 32'b001, 1);

        // ALU op 2 with a dropped press of op 5 during WAIT
        ey_base     = ey_pulses;
        operation   = 4'h2;
        btn_execute = 1'b1;
        tick();                                   // t
        chk("op t1 op_select", 32'(op_select), 2);
        chk("op t1 busy", 32'(busy), 1);
        chk("op t1 enable_Y", 32'(enable_Y), 0);
        chk("op t1 state", 32'(dbg_state), 1);
        btn_execute = 1'b0;
        tick();                                   // t+1
        chk("op t2 busy", 32'(busy), 1);
        chk("op t2 enable_Y", 32'(enable_Y), 0);
        operation   = 4'h5;
        btn_execute = 1'b1;
        tick();                                   // t+2, press dropped
        chk("op t3 op_select", 32'(op_select), 2);
        chk("op t3 busy", 32'(busy), 1);
        chk("op t3 enable_Y", 32'(enable_Y), 0);
        tick();                                   // t+3: WRITE
        chk("op t4 enable_Y", 32'(enable_Y), 1);
        chk("op t4 done", 32'(done), 1);
        chk("op t4 busy", 32'(busy), 1);
        chk("op t4 state", 32'(dbg_state), 2);
        chk("op t4 op_select", 32'(op_select), 2);
        tick();                                   // button still held
        chk_idle("op t5", 1, 2);
        tick();
        chk_idle("held past busy", 1, 2);
        btn_execute = 1'b0;
        tick();
        tick();
        chk("single enable_Y pulse", 32'(ey_pulses - ey_base), 1);

        // reset in the last WAIT cycle cancels the write
        ey_base     = ey_pulses;
        operation   = 4'h3;
        btn_execute = 1'b1;
        tick();
        btn_execute = 1'b0;
        chk("rst op op_select", 32'(op_select), 3);
        tick();
        tick();
        chk("rst op pre-write state", 32'(dbg_state), 1);
        chk("rst op pre-write enable_Y", 32'(enable_Y), 0);
        #2;
        reset = 1'b1;
        #1;
        chk_idle("async reset", 0, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        tick();
        chk_idle("after reset", 0, 0);
        chk("cancelled enable_Y", 32'(ey_pulses - ey_base), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
